// File: rtl/clint_regs.sv
// CLINT register block: msip, mtimecmp and mtime behind a
// single-outstanding valid/ready request/response port.
module clint_regs #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [ADDR_W-1:0] MSIP_OFF = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] MTIMECMP_OFF = ADDR_W'(16'h4000),
  parameter logic [ADDR_W-1:0] MTIME_OFF = ADDR_W'(16'hBFF8)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              trigger_edge,
  output logic [63:0]       count,
  output logic [63:0]       countcmp,
  output logic [63:0]       msip
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic [63:0] count_q;
  logic [63:0] cmp_q;
  logic        msip_q;

  logic        accept;
  logic        hit_m;
  logic        hit_c;
  logic        hit_t;
  logic        acc_err;
  logic        wr;
  logic [63:0] rd_val;
  logic [63:0] cnt_inc;

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] w,
    input logic [7:0]  s
  );
    logic [63:0] o;
    o = old;
    for (int i = 0; i < 8; i++)
      if (s[i]) o[8*i +: 8] = w[8*i +: 8];
    return o;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign count     = count_q;
  assign countcmp  = cmp_q;
  assign msip      = {63'b0, msip_q};

  always_comb begin
    hit_m   = (req_addr == MSIP_OFF);
    hit_c   = (req_addr == MTIMECMP_OFF);
    hit_t   = (req_addr == MTIME_OFF);
    acc_err = (req_addr[2:0] != 3'b0) || !(hit_m || hit_c || hit_t);
    wr      = accept && req_we && !acc_err;
    cnt_inc = count_q + 64'(trigger_edge);
    rd_val  = 64'b0;
    unique case (1'b1)
      hit_m:   rd_val = {63'b0, msip_q};
      hit_c:   rd_val = cmp_q;
      hit_t:   rd_val = count_q;
      default: rd_val = 64'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'b0;
      rsp_err   <= 1'b0;
      count_q   <= 64'b0;
      cmp_q     <= '1;
      msip_q    <= 1'b0;
    end else begin
      // mtime write lands on the already-ticked value
      count_q <= (wr && hit_t) ?
                 merge(cnt_inc, req_wdata, req_wstrb) : cnt_inc;
      if (wr && hit_c)
        cmp_q <= merge(cmp_q, req_wdata, req_wstrb);
      if (wr && hit_m && req_wstrb[0])
        msip_q <= req_wdata[0];
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= (req_we || acc_err) ? 64'b0 : rd_val;
            rsp_err   <= acc_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_regs.sv
// Randomized bench for clint_regs against a behavioural
// register model updated once per clock.
module tb_clint_regs;

  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CMP  = 16'h4000;
  localparam logic [15:0] A_TIME = 16'hBFF8;

  logic        clk = 0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        trigger_edge;
  logic [63:0] count;
  logic [63:0] countcmp;
  logic [63:0] msip;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [63:0] m_cnt, m_cmp;
  logic        m_msip;
  bit          m_busy;
  logic [63:0] e_rdata;
  logic        e_err;

  clint_regs dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .trigger_edge(trigger_edge), .count(count),
    .countcmp(countcmp), .msip(msip)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bmerge(
    input logic [63:0] o, input logic [63:0] w,
    input logic [7:0] s
  );
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++)
      if (s[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [191:0] mregs();
    return {m_cnt, m_cmp, 63'b0, m_msip};
  endfunction

  // Advance the model with the inputs now driven, then clock.
  task automatic tick();
    logic [63:0] nc;
    bit ok;
    if (!rstn) begin
      m_cnt = 0; m_cmp = '1; m_msip = 0; m_busy = 0;
    end else begin
      nc = m_cnt + (trigger_edge ? 64'd1 : 64'd0);
      if (req_valid && !m_busy) begin
        ok = req_addr[2:0] == 0 &&
             (req_addr == A_MSIP || req_addr == A_CMP ||
              req_addr == A_TIME);
        e_err = !ok;
        e_rdata = 0;
        if (ok && !req_we)
          e_rdata = req_addr == A_MSIP ? {63'b0, m_msip} :
                    req_addr == A_CMP ? m_cmp : m_cnt;
        if (ok && req_we) begin
          if (req_addr == A_TIME) nc = bmerge(nc, req_wdata, req_wstrb);
          if (req_addr == A_CMP)
            m_cmp = bmerge(m_cmp, req_wdata, req_wstrb);
          if (req_addr == A_MSIP && req_wstrb[0]) m_msip = req_wdata[0];
        end
        m_busy = 1;
      end else if (m_busy && rsp_ready) begin
        m_busy = 0;
      end
      m_cnt = nc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit trig);
    trigger_edge = trig;
    tick();
    trigger_edge = 0;
  endtask

  // One full transaction; returns the response seen and req_ready
  task automatic do_req(
    input bit we, input logic [15:0] a, input logic [63:0] wd,
    input logic [7:0] ws, input bit trig,
    output logic v, output logic [63:0] rd, output logic er,
    output logic rr
  );
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = wd; req_wstrb = ws; trigger_edge = trig;
    tick();
    req_valid = 0; trigger_edge = 0;
    v = rsp_valid; rd = rsp_rdata; er = rsp_err; rr = req_ready;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rstn = 0; trigger_edge = 1;
    tick(); tick();
    trigger_edge = 0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {2'b0, 64'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h rdy=%b, want 0 0 0 1",
               rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    n_cmp++;
    if ({count, countcmp, msip} !== {64'd0, {64{1'b1}}, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_regs: got %h %h %h", count, countcmp, msip);
    end
    rstn = 1;
  endtask

  task automatic test_cmp_read();
    logic v, er, rr; logic [63:0] rd;
    do_req(0, A_CMP, 0, 0, 0, v, rd, er, rr);
    n_cmp++;
    if ({v, er, rr, rd} !== {3'b100, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_bad++;
      $display("FAIL cmp_read: got v=%b e=%b rdy=%b d=%h, want 1 0 0 ffff..",
               v, er, rr, rd);
    end
  endtask

  task automatic test_msip();
    logic v, er, rr; logic [63:0] rd;
    do_req(1, A_MSIP, '1, 8'hFF, 0, v, rd, er, rr);
    n_cmp++;
    if ({v, er, rd, msip} !== {2'b10, 64'd0, 64'd1}) begin
      n_bad++;
      $display("FAIL msip_write: got v=%b e=%b d=%h msip=%h, want 1 0 0 1",
               v, er, rd, msip);
    end
    do_req(0, A_MSIP, 0, 0, 0, v, rd, er, rr);
    n_cmp++;
    if ({v, er, rd} !== {2'b10, 64'd1}) begin
      n_bad++;
      $display("FAIL msip_read: got v=%b e=%b d=%h, want 1 0 1", v, er, rd);
    end
  endtask

  task automatic test_wrap();
    logic v, er, rr; logic [63:0] rd;
    do_req(1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, v, rd, er, rr);
    n_cmp++;
    if (count !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_bad++;
      $display("FAIL wrap_wr: got %h, want fffffffffffffffe", count);
    end
    idle(1);
    n_cmp++;
    if (count !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_max: got %h, want ffffffffffffffff", count);
    end
    idle(1);
    n_cmp++;
    if (count !== 64'd0) begin
      n_bad++;
      $display("FAIL wrap_zero: got %h, want 0", count);
    end
  endtask

  task automatic test_strobe_trig();
    logic v, er, rr; logic [63:0] rd;
    do_req(1, A_TIME, 64'd5, 8'hFF, 0, v, rd, er, rr);
    do_req(1, A_TIME, {8{8'hAA}}, 8'h0F, 1, v, rd, er, rr);
    n_cmp++;
    if ({er, count} !== {1'b0, 64'h0000_0000_AAAA_AAAA}) begin
      n_bad++;
      $display("FAIL strobe_trig: got e=%b cnt=%h, want 0 00000000aaaaaaaa",
               er, count);
    end
    do_req(1, A_CMP, 64'h1234, 8'h00, 0, v, rd, er, rr);
    n_cmp++;
    if ({v, er, countcmp} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_bad++;
      $display("FAIL zero_strobe: got v=%b e=%b cmp=%h", v, er, countcmp);
    end
  endtask

  task automatic test_err();
    logic v, er, rr; logic [63:0] rd;
    logic [191:0] snap;
    logic [15:0] bad [3];
    bad[0] = 16'h0004; bad[1] = 16'h1000; bad[2] = 16'h4001;
    snap = {count, countcmp, msip};
    for (int i = 0; i < 3; i++) begin
      do_req(i == 2, bad[i], '1, 8'hFF, 0, v, rd, er, rr);
      n_cmp++;
      if ({v, er, rd, count, countcmp, msip} !== {2'b11, 64'd0, snap}) begin
        n_bad++;
        $display("FAIL err_%h: got v=%b e=%b d=%h regs %h",
                 bad[i], v, er, rd, {count, countcmp, msip});
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] c0, d0;
    bit bad;
    c0 = count;
    req_valid = 1; req_we = 0; req_addr = A_TIME;
    tick();
    req_valid = 0;
    d0 = c0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      idle(i == 2 || i == 5 || i == 8);
      if (!(rsp_valid === 1 && rsp_rdata === d0 && rsp_err === 0 &&
            req_ready === 0)) bad = 1;
    end
    n_cmp++;
    if (bad || count !== c0 + 3) begin
      n_bad++;
      $display("FAIL stall: unstable=%b cnt=%h, want cnt %h",
               bad, count, c0 + 3);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_done: got v=%b rdy=%b, want 0 1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_we = 1; req_addr = A_MSIP;
    req_wdata = 1; req_wstrb = 8'hFF;
    tick();
    req_valid = 0;
    rstn = 0;
    tick();
    rstn = 1;
    n_cmp++;
    if ({rsp_valid, req_ready, msip} !== {2'b01, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_resp: got v=%b rdy=%b msip=%h",
               rsp_valid, req_ready, msip);
    end
    rstn = 0; req_valid = 1;
    tick();
    rstn = 1; req_valid = 0;
    n_cmp++;
    if ({rsp_valid, msip} !== {1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_accept: got v=%b msip=%h", rsp_valid, msip);
    end
  endtask

  task automatic test_random();
    logic v, er, rr; logic [63:0] rd, wd;
    logic [15:0] a;
    logic [7:0] ws;
    bit we;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: a = A_MSIP;
        1: a = A_CMP;
        2, 3: a = A_TIME;
        4: a = A_TIME + 16'($urandom_range(1, 7));
        default: a = 16'($urandom) & 16'hFFF8;
      endcase
      we = 1'($urandom);
      wd = {32'($urandom), 32'($urandom)};
      ws = 8'($urandom);
      for (int k = $urandom_range(0, 3); k > 0; k--)
        idle(1'($urandom));
      do_req(we, a, wd, ws, 1'($urandom), v, rd, er, rr);
      n_cmp++;
      if ({v, er, rd, rr} !== {1'b1, e_err, e_rdata, 1'b0} ||
          {count, countcmp, msip} !== mregs()) begin
        n_bad++;
        $display("FAIL rand%0d a=%h we=%b: got v=%b e=%b d=%h regs %h, want e=%b d=%h regs %h",
                 n, a, we, v, er, rd, {count, countcmp, msip},
                 e_err, e_rdata, mregs());
      end
    end
  endtask

  initial begin
    req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
    trigger_edge = 0; rstn = 0;
    m_busy = 0; e_rdata = 0; e_err = 0;
    m_cnt = 0; m_cmp = '1; m_msip = 0;
    test_reset();
    test_cmp_read();
    test_msip();
    test_wrap();
    test_strobe_trig();
    test_err();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
